debug_dma_sched: RTL and testbench
==================================

Name: debug_dma_sched

Overview:
Command scheduler in front of the debug DMA engine's command interface. It arbitrates between two requesters (host debug link, boot loader) and issues a paired addr/ctrl register write for one thread. It tracks per-thread busy state, blocking re-issue until the IU signals that thread's DMA is done. It also counts completions and flags malformed requests.

Parameters:
NTHREAD, 64, number of hardware threads
TIDW, 6, thread ID width (log2 NTHREAD)
ADDRW, 32, DMA memory address width
BUFAW, 10, DMA buffer address width
CNTW, 10, transfer word count width
LUTRAMPROT, 1, 1 = generate even parity bits on written regs, 0 = parity tied 0

Ports:
clk  in  1  IU clock (gclk.clk domain)
rstn  in  1  async active-low reset
req_valid  in  2  per-requester request valid (bit0 host, bit1 loader)
req_ready  out  2  per-requester accept pulse
req_tid  in  2*TIDW  target thread per requester
req_addr  in  2*ADDRW  start memory address per requester
req_buf_addr  in  2*BUFAW  start buffer address per requester
req_count  in  2*CNTW  word count per requester
req_cmd  in  2*2  dma command encoding per requester (NOP/OP/...)
cmd_tid  out  TIDW  thread ID to DMA register files
cmd_addr_we  out  1  addr reg write enable
cmd_addr_reg  out  ADDRW+1  {parity, addr}
cmd_ctrl_we  out  1  ctrl reg write enable
cmd_ctrl_reg  out  BUFAW+CNTW+2+1  {parity, buf_addr, count, cmd}
cmd_ack  in  1  DMA accepted ctrl write
dma_done  in  1  DMA finished for done_tid
done_tid  in  TIDW  thread completing
busy  out  NTHREAD  per-thread outstanding bitmap
done_cnt  out  16  total completions, wraps
req_err  out  2  per-requester reject pulse

Behaviour:
- Reset (rstn low, async): FSM=IDLE, busy=0, done_cnt=0, rr pointer=0 (host first). req_ready=0, req_err=0, all we=0, and cmd_* data=0.
- FSM: IDLE, ISSUE, WAIT_ACK.
- IDLE: a requester is eligible if valid is high and busy[tid] is 0 (registered bitmap).
- Round-robin arbitration: the rr pointer selects priority; on a grant the pointer moves to the other requester.
- On grant with count!=0 and cmd!=NOP:
  - latch the fields, pulse req_ready for the winner for 1 cycle, go to ISSUE.
- On grant with count==0 or cmd==NOP:
  - pulse req_ready and req_err together for that requester and stay in IDLE; nothing is written and busy is unchanged.
- ISSUE: drive cmd_addr_we=1 and cmd_ctrl_we=1 in the same cycle, with cmd_tid = latched tid.
  - addr = latched addr; ctrl = {buf_addr, count, cmd}.
  - parity = XOR of that reg's payload when LUTRAMPROT=1, else 0.
  - If cmd_ack=1 in this cycle: set busy[tid] and return to IDLE.
  - Else: go to WAIT_ACK with the write enables held.
- WAIT_ACK: hold the enables and data until cmd_ack=1, then set busy[tid] and go to IDLE.
- Minimum latency is 2 cycles from grant to the next grant.
- dma_done=1: clear busy[done_tid] and increment done_cnt (modulo 2^16) on the same edge.
- Simultaneous set and clear of the same bit: the set wins (this only occurs on a premature done).
- dma_done for a thread that is not busy: done_cnt still increments and busy stays 0.
- Busy thread requested: that requester is not eligible and waits. The other requester may be granted in the same cycle, so there is no head-of-line blocking across requesters.
- Both requesters target the same idle tid in one cycle: only the rr winner is granted. The loser sees busy set after the ack and waits.
- Reset mid-operation (any state): return to IDLE immediately, drop the enables, clear busy; no partial write is repeated.
- req_* inputs are sampled only in IDLE; they must stay stable while valid is high and ready is low.

Test Plan:
- Host req tid=3, addr=0x1000, buf=0, count=16, cmd=OP, cmd_ack tied 1 -> req_ready[0] pulse; next cycle both we=1 with tid=3, addr_reg=0x1000 with parity 1; busy[3]=1 one cycle later.
- Both requesters valid with distinct tids 5 and 7, rr=0 -> host granted first, loader granted 2 cycles later; busy[5] and busy[7] both set.
- Loader requests tid=3 while busy[3]=1; drive dma_done with done_tid=3 -> grant occurs the cycle after the busy bit clears; done_cnt increments by 1.
- Request with count=0 -> req_ready and req_err pulse together; no write enables, busy unchanged.
- cmd_ack held low for 4 cycles -> enables and data stable for 5 cycles; busy set only after the ack.
- Assert rstn low during WAIT_ACK -> enables drop to 0 immediately, busy=0, done_cnt=0; first grant after release goes to the host.

Source files
------------

// File: rtl/debug_dma_sched.sv
// debug_dma_sched: round-robin command scheduler in front of the debug DMA register files
// Ports:
//   clk, rstn                 IU clock, async active-low reset
//   req_valid/req_ready       per-requester handshake (bit0 host, bit1 loader)
//   req_tid/addr/buf_addr/
//   req_count/req_cmd         per-requester command fields, packed requester 0 in the low slice
//   cmd_tid, cmd_*_we/_reg    paired addr/ctrl register write, {parity, payload}
//   cmd_ack                   DMA accepted the ctrl write
//   dma_done, done_tid        completion for one thread
//   busy                      per-thread outstanding bitmap
//   done_cnt                  wrapping completion counter
//   req_err                   per-requester reject pulse (zero count or NOP)
module debug_dma_sched #(
    parameter int NTHREAD    = 64,
    parameter int TIDW       = 6,
    parameter int ADDRW      = 32,
    parameter int BUFAW      = 10,
    parameter int CNTW       = 10,
    parameter int LUTRAMPROT = 1
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [1:0]                  req_valid,
    output logic [1:0]                  req_ready,
    input  logic [2*TIDW-1:0]           req_tid,
    input  logic [2*ADDRW-1:0]          req_addr,
    input  logic [2*BUFAW-1:0]          req_buf_addr,
    input  logic [2*CNTW-1:0]           req_count,
    input  logic [3:0]                  req_cmd,
    output logic [TIDW-1:0]             cmd_tid,
    output logic                        cmd_addr_we,
    output logic [ADDRW:0]              cmd_addr_reg,
    output logic                        cmd_ctrl_we,
    output logic [BUFAW+CNTW+2:0]       cmd_ctrl_reg,
    input  logic                        cmd_ack,
    input  logic                        dma_done,
    input  logic [TIDW-1:0]             done_tid,
    output logic [NTHREAD-1:0]          busy,
    output logic [15:0]                 done_cnt,
    output logic [1:0]                  req_err
);
    localparam logic [1:0] NOP = 2'b00;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK} state_t;

    state_t             state, state_n;
    logic               rr, sel, grant, bad, issuing;
    logic [1:0]         elig;
    logic [TIDW-1:0]    tid_s, tid_q;
    logic [ADDRW-1:0]   addr_s, addr_q;
    logic [BUFAW-1:0]   buf_s, buf_q;
    logic [CNTW-1:0]    cnt_s, cnt_q;
    logic [1:0]         cmd_s, cmd_q;
    logic [NTHREAD-1:0] busy_n;

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) state <= IDLE;
        else state <= state_n;

    // rstn gating keeps the handshake pulses quiet while reset is held
    always_comb begin
        elig[0]      = rstn && state == IDLE && req_valid[0] && !busy[req_tid[TIDW-1:0]];
        elig[1]      = rstn && state == IDLE && req_valid[1] && !busy[req_tid[2*TIDW-1:TIDW]];
        sel          = elig[rr] ? rr : !rr;
        grant        = |elig;
        tid_s        = sel ? req_tid[2*TIDW-1:TIDW]        : req_tid[TIDW-1:0];
        addr_s       = sel ? req_addr[2*ADDRW-1:ADDRW]     : req_addr[ADDRW-1:0];
        buf_s        = sel ? req_buf_addr[2*BUFAW-1:BUFAW] : req_buf_addr[BUFAW-1:0];
        cnt_s        = sel ? req_count[2*CNTW-1:CNTW]      : req_count[CNTW-1:0];
        cmd_s        = sel ? req_cmd[3:2]                  : req_cmd[1:0];
        bad          = cnt_s == '0 || cmd_s == NOP;
        issuing      = state != IDLE;
        req_ready    = grant ? (sel ? 2'b10 : 2'b01) : 2'b00;
        req_err      = bad ? req_ready : 2'b00;
        cmd_addr_we  = issuing;
        cmd_ctrl_we  = issuing;
        state_n      = issuing ? (cmd_ack ? IDLE : WAIT_ACK) : (grant && !bad ? ISSUE : IDLE);
    end

    // set is applied after clear so a premature done cannot drop a fresh busy bit
    always_comb begin
        busy_n = busy;
        if (dma_done) busy_n[done_tid] = 1'b0;
        if (issuing && cmd_ack) busy_n[tid_q] = 1'b1;
    end

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            rr       <= 1'b0;
            busy     <= '0;
            done_cnt <= '0;
            tid_q    <= '0;
            addr_q   <= '0;
            buf_q    <= '0;
            cnt_q    <= '0;
            cmd_q    <= '0;
        end else begin
            rr       <= grant ? !sel : rr;
            busy     <= busy_n;
            done_cnt <= done_cnt + 16'(dma_done);
            if (grant && !bad) begin
                tid_q  <= tid_s;
                addr_q <= addr_s;
                buf_q  <= buf_s;
                cnt_q  <= cnt_s;
                cmd_q  <= cmd_s;
            end
        end

    assign cmd_tid      = tid_q;
    assign cmd_addr_reg = {(LUTRAMPROT != 0) & (^addr_q), addr_q};
    assign cmd_ctrl_reg = {(LUTRAMPROT != 0) & (^{buf_q, cnt_q, cmd_q}), buf_q, cnt_q, cmd_q};
endmodule

// File: tb/tb_debug_dma_sched.sv
// tb_debug_dma_sched: directed and random checks of debug_dma_sched against a transaction-level model
module tb_debug_dma_sched;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [1:0]  req_valid = '0, req_ready, req_err;
    logic [11:0] req_tid = '0;
    logic [63:0] req_addr = '0;
    logic [19:0] req_buf_addr = '0, req_count = '0;
    logic [3:0]  req_cmd = '0;
    logic [5:0]  cmd_tid, done_tid = '0;
    logic        cmd_addr_we, cmd_ctrl_we, cmd_ack = 1'b0, dma_done = 1'b0;
    logic [32:0] cmd_addr_reg;
    logic [22:0] cmd_ctrl_reg;
    logic [63:0] busy;
    logic [15:0] done_cnt;

    int n_chk = 0, n_err = 0;

    logic [63:0] m_busy;
    logic [15:0] m_cnt;
    logic        m_pend, m_rr;
    logic [5:0]  m_tid;
    logic [31:0] m_addr;
    logic [9:0]  m_buf, m_count;
    logic [1:0]  m_cmd;
    logic [1:0]  e_ready, e_err;

    always #5 clk = ~clk;

    debug_dma_sched dut (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
        .req_tid(req_tid), .req_addr(req_addr), .req_buf_addr(req_buf_addr),
        .req_count(req_count), .req_cmd(req_cmd), .cmd_tid(cmd_tid),
        .cmd_addr_we(cmd_addr_we), .cmd_addr_reg(cmd_addr_reg),
        .cmd_ctrl_we(cmd_ctrl_we), .cmd_ctrl_reg(cmd_ctrl_reg), .cmd_ack(cmd_ack),
        .dma_done(dma_done), .done_tid(done_tid), .busy(busy), .done_cnt(done_cnt),
        .req_err(req_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task model_reset;
        m_busy = '0; m_cnt = '0; m_pend = 1'b0; m_rr = 1'b0;
        m_tid = '0; m_addr = '0; m_buf = '0; m_count = '0; m_cmd = '0;
    endtask

    task automatic set_req(input int i, input logic [5:0] t, input logic [31:0] a,
                           input logic [9:0] b, input logic [9:0] c, input logic [1:0] k);
        req_tid[i*6 +: 6]       = t;
        req_addr[i*32 +: 32]    = a;
        req_buf_addr[i*10 +: 10] = b;
        req_count[i*10 +: 10]   = c;
        req_cmd[i*2 +: 2]       = k;
        req_valid[i]            = 1'b1;
    endtask

    task model_check;
        logic [1:0] el;
        int w;
        if (!rstn) model_reset;
        el[0] = req_valid[0] && !m_busy[req_tid[5:0]];
        el[1] = req_valid[1] && !m_busy[req_tid[11:6]];
        e_ready = '0;
        e_err = '0;
        if (rstn && !m_pend && el != 0) begin
            w = el[m_rr] ? int'(m_rr) : int'(!m_rr);
            e_ready[w] = 1'b1;
            e_err[w] = req_count[w*10 +: 10] == 0 || req_cmd[w*2 +: 2] == 0;
        end
        chk("ready", req_ready, e_ready);
        chk("err", req_err, e_err);
        chk("addr_we", cmd_addr_we, m_pend);
        chk("ctrl_we", cmd_ctrl_we, m_pend);
        if (m_pend) begin
            chk("cmd_tid", cmd_tid, m_tid);
            chk("addr_reg", cmd_addr_reg, {1'($countones(m_addr) % 2), m_addr});
            chk("ctrl_reg", cmd_ctrl_reg,
                {1'(($countones(m_buf) + $countones(m_count) + $countones(m_cmd)) % 2), m_buf, m_count, m_cmd});
        end
        chk("busy", busy, m_busy);
        chk("done_cnt", done_cnt, m_cnt);
    endtask

    task model_update;
        logic set_en;
        logic [5:0] st;
        int w;
        if (!rstn) begin
            model_reset;
            return;
        end
        set_en = m_pend && cmd_ack;
        st = m_tid;
        if (m_pend) m_pend = !cmd_ack;
        else if (e_ready != 0) begin
            w = int'(e_ready[1]);
            m_rr = !e_ready[1];
            if (e_err == 0) begin
                m_tid = req_tid[w*6 +: 6];
                m_addr = req_addr[w*32 +: 32];
                m_buf = req_buf_addr[w*10 +: 10];
                m_count = req_count[w*10 +: 10];
                m_cmd = req_cmd[w*2 +: 2];
                m_pend = 1'b1;
            end
            req_valid[w] = 1'b0;
        end
        if (dma_done) begin
            m_busy[done_tid] = 1'b0;
            m_cnt++;
        end
        if (set_en) m_busy[st] = 1'b1;
    endtask

    task tick;
        @(negedge clk);
        model_check;
        @(posedge clk);
        #1;
        model_update;
        #1;
    endtask

    task do_reset;
        rstn = 1'b0;
        req_valid = '0;
        dma_done = 1'b0;
        tick;
        tick;
        rstn = 1'b1;
    endtask

    initial begin
        model_reset;
        do_reset;
        chk("rst_busy", busy, 64'h0);
        chk("rst_cnt", done_cnt, 16'h0);

        cmd_ack = 1'b1;
        set_req(0, 6'd3, 32'h1000, 10'd0, 10'd16, 2'b01);
        #1 chk("t1_ready", req_ready, 2'b01);
        tick;
        chk("t1_we", {cmd_addr_we, cmd_ctrl_we}, 2'b11);
        chk("t1_tid", cmd_tid, 6'd3);
        chk("t1_addr", cmd_addr_reg, 33'h1_0000_1000);
        chk("t1_ctrl", cmd_ctrl_reg, 23'h41);
        tick;
        chk("t1_busy3", busy[3], 1'b1);

        do_reset;
        cmd_ack = 1'b1;
        set_req(0, 6'd5, 32'h2000, 10'd1, 10'd4, 2'b01);
        set_req(1, 6'd7, 32'h3000, 10'd2, 10'd8, 2'b10);
        #1 chk("t2_host", req_ready, 2'b01);
        tick;
        tick;
        chk("t2_loader", req_ready, 2'b10);
        tick;
        tick;
        chk("t2_busy5", busy[5], 1'b1);
        chk("t2_busy7", busy[7], 1'b1);

        set_req(0, 6'd3, 32'h4000, 10'd3, 10'd4, 2'b01);
        tick;
        tick;
        set_req(1, 6'd3, 32'h5000, 10'd4, 10'd2, 2'b01);
        #1 chk("t3_blocked", req_ready, 2'b00);
        tick;
        chk("t3_blocked2", req_ready, 2'b00);
        dma_done = 1'b1;
        done_tid = 6'd3;
        tick;
        dma_done = 1'b0;
        #1 chk("t3_grant", req_ready, 2'b10);
        chk("t3_cnt", done_cnt, 16'd1);
        tick;
        tick;
        chk("t3_busy3", busy[3], 1'b1);

        set_req(0, 6'd20, 32'h6000, 10'd5, 10'd0, 2'b01);
        #1 chk("t4_ready", req_ready, 2'b01);
        chk("t4_err", req_err, 2'b01);
        tick;
        chk("t4_we", {cmd_addr_we, cmd_ctrl_we}, 2'b00);
        chk("t4_busy20", busy[20], 1'b0);

        cmd_ack = 1'b0;
        set_req(0, 6'd9, 32'hdead_beef, 10'h155, 10'h3ff, 2'b11);
        tick;
        for (int i = 0; i < 4; i++) begin
            chk("t5_we", {cmd_addr_we, cmd_ctrl_we}, 2'b11);
            chk("t5_addr", cmd_addr_reg[31:0], 32'hdead_beef);
            chk("t5_busy9", busy[9], 1'b0);
            tick;
        end
        chk("t5_we_last", {cmd_addr_we, cmd_ctrl_we}, 2'b11);
        cmd_ack = 1'b1;
        tick;
        chk("t5_busy9_set", busy[9], 1'b1);
        chk("t5_we_off", {cmd_addr_we, cmd_ctrl_we}, 2'b00);

        cmd_ack = 1'b0;
        set_req(0, 6'd11, 32'h7000, 10'd6, 10'd3, 2'b01);
        tick;
        tick;
        rstn = 1'b0;
        #1 chk("t6_we", {cmd_addr_we, cmd_ctrl_we}, 2'b00);
        chk("t6_busy", busy, 64'h0);
        chk("t6_cnt", done_cnt, 16'h0);
        tick;
        tick;
        rstn = 1'b1;
        set_req(0, 6'd12, 32'h8000, 10'd7, 10'd1, 2'b01);
        set_req(1, 6'd13, 32'h9000, 10'd8, 10'd1, 2'b01);
        #1 chk("t6_host_first", req_ready, 2'b01);

        for (int n = 0; n < 2000; n++) begin
            for (int i = 0; i < 2; i++)
                if (!req_valid[i] && $urandom_range(2) != 0)
                    set_req(i, 6'($urandom_range(7)), $urandom, 10'($urandom),
                            $urandom_range(7) == 0 ? 10'd0 : 10'($urandom), 2'($urandom));
            cmd_ack = 1'($urandom_range(1));
            dma_done = $urandom_range(3) == 0;
            done_tid = 6'($urandom_range(7));
            tick;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
